// File: rtl/reset_vector_collector_pkg.sv
// Shared constants, FSM encoding and the nibble-to-ASCII helper for the
// reset-vector collector.
package reset_vector_collector_pkg;

  localparam int         CHUNK_W   = 2;
  localparam int         BYTE_N    = 7;
  localparam logic [4:0] IDLE_ADDR = 5'h1F;
  localparam logic [7:0] CR_BYTE   = 8'h0D;
  localparam logic [7:0] LF_BYTE   = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PROBE,
    ST_SEND,
    ST_DONE
  } state_t;

  // Uppercase hex digit: 0-9 -> '0'-'9', A-F -> 'A'-'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/reset_vector_collector_if.sv
// Bus between the collector, the prober and the bench host: probe port,
// parallel result, status, UART line and a debug view of the FSM state.
interface reset_vector_collector_if #(
  parameter int ADDR_N = 19
);
  import reset_vector_collector_pkg::*;

  logic               start;
  logic [4:0]         probe_addr;
  logic [CHUNK_W-1:0] probe_data;
  logic [ADDR_N-1:0]  vector;
  logic               vector_valid;
  logic               busy;
  logic               tx;
  state_t             state;

  modport master (
    input  start, probe_data,
    output probe_addr, vector, vector_valid, busy, tx, state
  );

  modport slave (
    output start, probe_data,
    input  probe_addr, vector, vector_valid, busy, tx, state
  );

endinterface

// File: rtl/reset_vector_collector_uart_tx.sv
// 8N1 UART transmitter: start bit 0, eight data bits LSB first, stop bit 1,
// each bit exactly BAUD_DIV clocks; tx idles high.
module uart_tx_8n1 #(
  parameter int BAUD_DIV = 434
) (
  input  logic       i_clk,
  input  logic       _rst,
  input  logic [7:0] data,
  input  logic       load,
  output logic       tx,
  output logic       ready
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [8:0]       shreg;
  logic             active;
  logic             bit_end;

  assign bit_end = (baud_cnt == CNT_W'(BAUD_DIV - 1));

  // Handshake: a byte is taken on a rising edge where load && ready. ready is
  // high while idle and in the final cycle of a stop bit, so frames chain.
  assign ready = !active || (bit_end && bit_cnt == 4'd9);

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      tx       <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '1;
    end else if (load && ready) begin
      tx       <= 1'b0;
      shreg    <= {1'b1, data};
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (active) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
        end else begin
          tx      <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/reset_vector_collector.sv
// Walks the prober's chunk index, rebuilds the reset address, presents it in
// parallel and sends it once as "XXXXX\r\n" over the UART.
module reset_vector_collector
  import reset_vector_collector_pkg::*;
#(
  parameter int ADDR_N   = 19,
  parameter int CHUNK_N  = 10,
  parameter int BAUD_DIV = 434
) (
  input  logic                     i_clk,
  input  logic                     _rst,
  reset_vector_collector_if.master bus
);

  state_t            state, state_next;
  logic [4:0]        idx;
  logic [2:0]        byte_idx;
  logic              start_q;
  logic [ADDR_N-1:0] vector, vector_next;
  logic              vector_valid;
  logic              last_chunk;
  logic              load;
  logic [7:0]        load_data;
  logic              uart_ready;

  function automatic logic [7:0] byte_at(input logic [2:0] sel, input logic [ADDR_N-1:0] v);
    logic [19:0] w;
    w = 20'(v);
    case (sel)
      3'd0:    return hex_ascii(w[19:16]);
      3'd1:    return hex_ascii(w[15:12]);
      3'd2:    return hex_ascii(w[11:8]);
      3'd3:    return hex_ascii(w[7:4]);
      3'd4:    return hex_ascii(w[3:0]);
      3'd5:    return CR_BYTE;
      default: return LF_BYTE;
    endcase
  endfunction

  assign last_chunk = (idx == 5'(CHUNK_N - 1));

  // The final chunk only carries the address MSB; its upper bit is dropped.
  always_comb begin
    vector_next = vector;
    if (last_chunk) begin
      vector_next[ADDR_N-1] = bus.probe_data[0];
    end else begin
      for (int k = 0; k < CHUNK_N - 1; k++) begin
        if (idx == 5'(k)) vector_next[CHUNK_W*k +: CHUNK_W] = bus.probe_data;
      end
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_data  = 8'h00;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start_q)                state_next = ST_PROBE;
        else if (state == ST_DONE)  state_next = ST_IDLE;
      end
      ST_PROBE: begin
        if (last_chunk) begin
          state_next = ST_SEND;
          load       = 1'b1;
          load_data  = byte_at(3'd0, vector_next);
        end
      end
      ST_SEND: begin
        if (uart_ready) begin
          if (byte_idx == 3'(BYTE_N - 1)) begin
            state_next = ST_DONE;
          end else begin
            load      = 1'b1;
            load_data = byte_at(byte_idx + 3'd1, vector);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // start is registered first so the prober sees index 0 a full cycle later.
  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      start_q      <= 1'b0;
      idx          <= '0;
      byte_idx     <= '0;
      vector       <= '0;
      vector_valid <= 1'b0;
    end else begin
      start_q <= bus.start;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_q) begin
            idx          <= '0;
            vector_valid <= 1'b0;
          end
        end
        ST_PROBE: begin
          vector <= vector_next;
          idx    <= idx + 5'd1;
          if (last_chunk) begin
            vector_valid <= 1'b1;
            byte_idx     <= '0;
          end
        end
        ST_SEND: begin
          if (load) byte_idx <= byte_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

  uart_tx_8n1 #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .i_clk (i_clk),
    ._rst  (_rst),
    .data  (load_data),
    .load  (load),
    .tx    (bus.tx),
    .ready (uart_ready)
  );

  assign bus.probe_addr   = (state == ST_PROBE) ? idx : IDLE_ADDR;
  assign bus.busy         = (state == ST_PROBE) || (state == ST_SEND);
  assign bus.vector       = vector;
  assign bus.vector_valid = vector_valid;
  assign bus.state        = state;

endmodule

// File: tb/tb_reset_vector_collector.sv
// Bench for reset_vector_collector: prober model, timeline-based reference,
// UART decoder scoreboard and directed cases.
module tb_reset_vector_collector;

  localparam int BAUD    = 4;
  localparam int FRAME   = 10 * BAUD;
  localparam int RUN_LEN = 11 + 7 * FRAME;

  logic i_clk = 1'b0;
  logic _rst  = 1'b1;

  reset_vector_collector_if #(.ADDR_N(19)) bus();

  reset_vector_collector #(.ADDR_N(19), .CHUNK_N(10), .BAUD_DIV(BAUD)) dut (
    .i_clk (i_clk),
    ._rst  (_rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- prober model (updates on falling edge) ----------------
  logic [18:0] word     = '0;
  logic        hi_extra = 1'b0;

  always @(negedge i_clk) begin
    int a;
    a = int'(bus.probe_addr);
    if (a < 9)       bus.probe_data <= 2'(word >> (2 * a));
    else if (a == 9) bus.probe_data <= {hi_extra, word[18]};
    else             bus.probe_data <= 2'b00;
  end

  // ---------------- reference: timeline from the accepted start ----------------
  int          n       = 0;
  int          t0      = 0;
  bit          run     = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_fresh = 1'b1;
  logic [18:0] m_vec   = '0;

  function automatic logic [7:0] hex_chr(input int v);
    return (v < 10) ? 8'(48 + v) : 8'(55 + v);
  endfunction

  function automatic logic [7:0] model_byte(input int k, input logic [18:0] w);
    if (k <= 4) return hex_chr((int'(w) >> (4 * (4 - k))) & 15);
    if (k == 5) return 8'h0D;
    return 8'h0A;
  endfunction

  function automatic logic tx_at(input int d, input logic [18:0] w);
    int off, bitn;
    logic [7:0] b;
    if (d < 11 || d >= RUN_LEN) return 1'b1;
    off  = d - 11;
    b    = model_byte(off / FRAME, w);
    bitn = (off % FRAME) / BAUD;
    if (bitn == 0) return 1'b0;
    if (bitn == 9) return 1'b1;
    return b[bitn-1];
  endfunction

  always @(posedge i_clk or negedge _rst) begin
    int d;
    if (!_rst) begin
      run     = 1'b0;
      m_valid = 1'b0;
      m_fresh = 1'b1;
      m_vec   = '0;
    end else begin
      n++;
      if (bus.start && (!run || n - t0 >= RUN_LEN)) begin
        run     = 1'b1;
        t0      = n;
        m_fresh = 1'b0;
      end else if (run) begin
        d = n - t0;
        if (d == 1) m_valid = 1'b0;
        if (d == 11) begin
          m_valid = 1'b1;
          m_vec   = word;
        end
      end
    end
  end

  always @(negedge i_clk) begin
    int d;
    logic [4:0] e_addr;
    logic e_busy, e_tx;
    if (_rst === 1'b1) begin
      d      = run ? n - t0 : -1;
      e_addr = (d >= 1 && d <= 10) ? 5'(d - 1) : 5'h1F;
      e_busy = (d >= 1 && d < RUN_LEN);
      e_tx   = run ? tx_at(d, m_vec) : 1'b1;
      chk("probe_addr", {27'd0, bus.probe_addr}, {27'd0, e_addr});
      chk("busy", {31'd0, bus.busy}, {31'd0, e_busy});
      chk("tx", {31'd0, bus.tx}, {31'd0, e_tx});
      chk("vector_valid", {31'd0, bus.vector_valid}, {31'd0, m_valid});
      if (m_valid || m_fresh) chk("vector", {13'd0, bus.vector}, {13'd0, m_vec});
    end
  end

  // ---------------- UART decoder + scoreboard ----------------
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  bit         rx_on = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;

  always @(negedge i_clk) begin
    int i;
    if (_rst !== 1'b1) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (bus.tx == 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= BAUD + BAUD / 2 && (rx_cnt - BAUD / 2) % BAUD == 0) begin
        i = (rx_cnt - BAUD / 2) / BAUD;
        if (i <= 8) begin
          rx_byte[i-1] = bus.tx;
        end else begin
          chk("stop_bit", {31'd0, bus.tx}, 32'd1);
          rx_q.push_back(rx_byte);
          rx_on = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge i_clk); #1 bus.start = 1'b1;
    @(posedge i_clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_cycles(input int c);
    repeat (c) @(posedge i_clk);
    #1;
  endtask

  task automatic expect_text(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic check_rx(input string name);
    logic [7:0] e, a;
    chk({name, "_frames"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      chk({name, "_byte"}, {24'd0, a}, {24'd0, e});
    end
    rx_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed cases ----------------
  initial begin
    int lows;
    bus.start = 1'b0;
    #3 _rst = 1'b0;
    #1;
    chk("rst_probe_addr", {27'd0, bus.probe_addr}, 32'h1F);
    chk("rst_vector", {13'd0, bus.vector}, 32'd0);
    chk("rst_valid", {31'd0, bus.vector_valid}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_tx", {31'd0, bus.tx}, 32'd1);
    repeat (3) @(negedge i_clk);
    #1 _rst = 1'b1;
    wait_cycles(3);

    // 4BEEF: index walk and first-transmit timing
    word = 19'h4BEEF; hi_extra = 1'b0;
    expect_text("4BEEF");
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      chk("probe_step", {27'd0, bus.probe_addr}, k);
    end
    @(posedge i_clk); #1;
    chk("c1_valid_t11", {31'd0, bus.vector_valid}, 32'd1);
    chk("c1_vector_t11", {13'd0, bus.vector}, 32'h4BEEF);
    chk("c1_tx_start_bit", {31'd0, bus.tx}, 32'd0);
    wait_cycles(RUN_LEN - 11 + 4);
    chk("c1_busy_end", {31'd0, bus.busy}, 32'd0);
    check_rx("c1");

    // 7FFFF with the discarded upper bit of chunk 9 set
    word = 19'h7FFFF; hi_extra = 1'b1;
    expect_text("7FFFF");
    pulse_start();
    wait_cycles(RUN_LEN + 4);
    chk("c2_vector", {13'd0, bus.vector}, 32'h7FFFF);
    check_rx("c2");

    // 00000: '0' = 0x30, start bit plus four zero data bits is 5 bit times low
    word = 19'h00000; hi_extra = 1'b0;
    expect_text("00000");
    pulse_start();
    wait_cycles(11);
    lows = 0;
    while (bus.tx == 1'b0 && lows < 100) begin
      lows++;
      @(posedge i_clk); #1;
    end
    chk("c3_low_run", lows, 5 * BAUD);
    wait_cycles(RUN_LEN - 11 - lows + 4);
    check_rx("c3");

    // start re-pulsed during SEND must be ignored
    word = 19'h2A5C3;
    expect_text("2A5C3");
    pulse_start();
    wait_cycles(11 + 30);
    pulse_start();
    wait_cycles(RUN_LEN + 4);
    chk("c4_vector", {13'd0, bus.vector}, 32'h2A5C3);
    check_rx("c4");

    // reset in the middle of byte 2 ('3', data bit 2 low at this point)
    word = 19'h12345;
    pulse_start();
    wait_cycles(104);
    chk("c5_tx_pre_rst", {31'd0, bus.tx}, 32'd0);
    #2 _rst = 1'b0;
    #1;
    chk("c5_rst_tx", {31'd0, bus.tx}, 32'd1);
    chk("c5_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("c5_rst_vector", {13'd0, bus.vector}, 32'd0);
    chk("c5_rst_valid", {31'd0, bus.vector_valid}, 32'd0);
    chk("c5_rst_probe_addr", {27'd0, bus.probe_addr}, 32'h1F);
    @(negedge i_clk); #1 _rst = 1'b1;
    rx_q.delete();
    exp_q.delete();
    word = 19'h4BEEF;
    expect_text("4BEEF");
    pulse_start();
    wait_cycles(RUN_LEN + 4);
    chk("c5_vector", {13'd0, bus.vector}, 32'h4BEEF);
    check_rx("c5");

    // two sequential collections with a changed prober value
    word = 19'h12345;
    expect_text("12345");
    pulse_start();
    wait_cycles(RUN_LEN + 4);
    chk("c6a_vector", {13'd0, bus.vector}, 32'h12345);
    check_rx("c6a");
    word = 19'h6789A;
    expect_text("6789A");
    pulse_start();
    for (int k = 0; k < 10; k++) begin
      @(posedge i_clk); #1;
      chk("c6_valid_low_probe", {31'd0, bus.vector_valid}, 32'd0);
    end
    @(posedge i_clk); #1;
    chk("c6b_valid", {31'd0, bus.vector_valid}, 32'd1);
    chk("c6b_vector", {13'd0, bus.vector}, 32'h6789A);
    wait_cycles(RUN_LEN - 11 + 4);
    check_rx("c6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
